// File: rtl/rover_location_to_cartesian.sv
// Converts a polar rover fix {angle code, distance} into screen pixel
// coordinates. A rising edge on location_done starts a conversion: a sin/cos
// ROM lookup, a 9-cycle parallel shift-add multiply, then scale and origin
// offset. Results appear with a one-cycle result_valid pulse and hold between
// conversions.
module rover_location_to_cartesian #(
  parameter int ORIGIN_X    = 512,
  parameter int ORIGIN_Y    = 700,
  parameter int SCALE_SHIFT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        location_done,
  input  logic [11:0] rover_location,
  output logic        busy,
  output logic        result_valid,
  output logic [10:0] x_pixel,
  output logic [9:0]  y_pixel,
  output logic        angle_error,
  output logic        no_target
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MULTIPLY,
    OFFSET,
    DONE
  } state_t;

  state_t      state;
  logic        done_hist;
  logic [3:0]  angle_q;
  logic [7:0]  dist_q;
  logic [8:0]  cos_coef;
  logic [8:0]  sin_coef;
  logic        cos_neg;
  logic [16:0] acc_cos;
  logic [16:0] acc_sin;
  logic [3:0]  bit_idx;

  logic [8:0]  rom_cos;
  logic [8:0]  rom_sin;
  logic [16:0] dist_shift;
  logic [10:0] px;
  logic [9:0]  py;
  logic [10:0] x_next;
  logic [9:0]  y_next;

  // Q1.8 magnitudes of cos/sin for k*15 degrees; sign of cos handled separately.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    rom_cos = 9'd0;
    rom_sin = 9'd0;
    case (angle_q)
      4'd0:  begin rom_cos = 9'd256; rom_sin = 9'd0;   end
      4'd1:  begin rom_cos = 9'd247; rom_sin = 9'd66;  end
      4'd2:  begin rom_cos = 9'd222; rom_sin = 9'd128; end
      4'd3:  begin rom_cos = 9'd181; rom_sin = 9'd181; end
      4'd4:  begin rom_cos = 9'd128; rom_sin = 9'd222; end
      4'd5:  begin rom_cos = 9'd66;  rom_sin = 9'd247; end
      4'd6:  begin rom_cos = 9'd0;   rom_sin = 9'd256; end
      4'd7:  begin rom_cos = 9'd66;  rom_sin = 9'd247; end
      4'd8:  begin rom_cos = 9'd128; rom_sin = 9'd222; end
      4'd9:  begin rom_cos = 9'd181; rom_sin = 9'd181; end
      4'd10: begin rom_cos = 9'd222; rom_sin = 9'd128; end
      4'd11: begin rom_cos = 9'd247; rom_sin = 9'd66;  end
      default: ;
    endcase
  end

  // Shifted partial product and the scaled, origin-relative coordinates.
  always_comb begin
    dist_shift = 17'(dist_q) << bit_idx;
    px         = 11'(acc_cos[16:8]) << SCALE_SHIFT;
    py         = 10'(acc_sin[16:8]) << SCALE_SHIFT;
    x_next     = cos_neg ? (11'(ORIGIN_X) - px) : (11'(ORIGIN_X) + px);
    y_next     = 10'(ORIGIN_Y) - py;
  end

  // Conversion FSM with registered outputs; edge history tracks every cycle.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (reset) begin
      state        <= IDLE;
      done_hist    <= 1'b1;
      angle_q      <= 4'd0;
      dist_q       <= 8'd0;
      cos_coef     <= 9'd0;
      sin_coef     <= 9'd0;
      cos_neg      <= 1'b0;
      acc_cos      <= 17'd0;
      acc_sin      <= 17'd0;
      bit_idx      <= 4'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      x_pixel      <= 11'(ORIGIN_X);
      y_pixel      <= 10'(ORIGIN_Y);
      angle_error  <= 1'b0;
      no_target    <= 1'b0;
    end else begin
      done_hist    <= location_done;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (location_done && !done_hist) begin
            angle_q <= rover_location[11:8];
            dist_q  <= rover_location[7:0];
            busy    <= 1'b1;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (angle_q >= 4'd12) begin
            angle_error  <= 1'b1;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            angle_error <= 1'b0;
            cos_coef    <= rom_cos;
            sin_coef    <= rom_sin;
            cos_neg     <= (angle_q >= 4'd7);
            acc_cos     <= 17'd0;
            acc_sin     <= 17'd0;
            bit_idx     <= 4'd0;
            state       <= MULTIPLY;
          end
        end
        MULTIPLY: begin
          if (cos_coef[bit_idx]) acc_cos <= acc_cos + dist_shift;
          if (sin_coef[bit_idx]) acc_sin <= acc_sin + dist_shift;
          if (bit_idx == 4'd8) state <= OFFSET;
          else                 bit_idx <= bit_idx + 4'd1;
        end
        OFFSET: begin
          x_pixel      <= x_next;
          y_pixel      <= y_next;
          no_target    <= (dist_q == 8'd0);
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rover_location_to_cartesian.sv
// Directed bench for rover_location_to_cartesian. Stimulus pushes hand-computed
// results into a scoreboard queue; a monitor pops and compares on every
// result_valid. The stimulus task also checks latency, busy and pulse counts.
module tb_rover_location_to_cartesian;

  logic        clock = 1'b0;
  logic        reset;
  logic        location_done;
  logic [11:0] rover_location;
  logic        busy;
  logic        result_valid;
  logic [10:0] x_pixel;
  logic [9:0]  y_pixel;
  logic        angle_error;
  logic        no_target;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic        ae;
    logic        nt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  rover_location_to_cartesian dut (
    .clock          (clock),
    .reset          (reset),
    .location_done  (location_done),
    .rover_location (rover_location),
    .busy           (busy),
    .result_valid   (result_valid),
    .x_pixel        (x_pixel),
    .y_pixel        (y_pixel),
    .angle_error    (angle_error),
    .no_target      (no_target)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic push(input int x, input int y, input bit ae, input bit nt);
    exp_t e;
    e.x  = 11'(x);
    e.y  = 10'(y);
    e.ae = ae;
    e.nt = nt;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each presented result against the oldest expectation.
  always @(negedge clock) begin
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("x_pixel", int'(x_pixel), int'(e.x));
        check("y_pixel", int'(y_pixel), int'(e.y));
        check("angle_error", int'(angle_error), int'(e.ae));
        check("no_target", int'(no_target), int'(e.nt));
      end
    end
  end

  // Issue one start edge at cycle E and watch E+1..E+25.
  // reedge: cycle offset of a second edge while busy (0 = none).
  // rst_at: cycle offset at which reset is asserted (0 = none).
  task automatic run_conv(input logic [11:0] loc, input int exp_lat,
                          input int reedge, input int rst_at);
    int valids;
    int first;
    int busy_bad;
    @(negedge clock);
    rover_location = loc;
    location_done  = 1'b1;
    @(posedge clock);
    valids   = 0;
    first    = 0;
    busy_bad = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clock);
      if (result_valid) begin
        valids++;
        if (first == 0) first = n;
      end
      if (rst_at == 0) begin
        if (n <= exp_lat && !busy) busy_bad++;
        if (n == exp_lat + 1 && busy) busy_bad++;
      end
      if (n == 1) location_done = 1'b0;
      if (reedge > 0 && n == reedge) location_done = 1'b1;
      if (reedge > 0 && n == reedge + 1) location_done = 1'b0;
      if (rst_at > 0 && n == rst_at) reset = 1'b1;
      if (rst_at > 0 && n == rst_at + 1) begin
        check("abort_busy", int'(busy), 0);
        check("abort_x", int'(x_pixel), 512);
        check("abort_y", int'(y_pixel), 700);
        reset = 1'b0;
      end
    end
    if (rst_at == 0) begin
      check("valid_count", valids, 1);
      check("latency", first, exp_lat);
      check("busy_window", busy_bad, 0);
    end else begin
      check("abort_valid_count", valids, 0);
    end
  endtask

  initial begin
    int busy_seen;
    reset          = 1'b1;
    location_done  = 1'b0;
    rover_location = 12'h000;
    repeat (3) @(negedge clock);
    check("rst_x", int'(x_pixel), 512);
    check("rst_y", int'(y_pixel), 700);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(result_valid), 0);
    check("rst_angle_error", int'(angle_error), 0);
    check("rst_no_target", int'(no_target), 0);

    // Done level held high through reset release must not start anything.
    location_done = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (busy || result_valid) busy_seen++;
    end
    check("held_done_no_start", busy_seen, 0);
    location_done = 1'b0;
    repeat (2) @(negedge clock);

    // Angle 6, distance 100: straight up.
    push(512, 500, 1'b0, 1'b0);
    run_conv(12'h664, 12, 0, 0);

    // Angle 1, distance 200.
    push(896, 598, 1'b0, 1'b0);
    run_conv(12'h1C8, 12, 0, 0);

    // Angle 9, distance 255: negative cos.
    push(152, 340, 1'b0, 1'b0);
    run_conv(12'h9FF, 12, 0, 0);

    // Angle 13: error, coordinates and no_target held.
    push(152, 340, 1'b1, 1'b0);
    run_conv(12'hD50, 2, 0, 0);

    // Angle 3, distance 0: no target at origin.
    push(512, 700, 1'b0, 1'b1);
    run_conv(12'h300, 12, 0, 0);

    // Second edge at E+5 while busy is dropped.
    push(896, 598, 1'b0, 1'b0);
    run_conv(12'h1C8, 12, 5, 0);

    // Reset at E+6 aborts with no result, then a fresh conversion.
    run_conv(12'h9FF, 12, 0, 6);
    push(512, 500, 1'b0, 1'b0);
    run_conv(12'h664, 12, 0, 0);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rover_location_to_cartesian.md
Name: rover_location_to_cartesian

Overview:
- Consumes the 12-bit polar rover fix {angle[11:8], distance[7:0]} and its done level from the ultrasound location calculator.
- Converts the fix into screen pixel coordinates for the display overlay.
- Angle code k is k*15 degrees, valid for k = 0..11. Distance is in inches.
- Uses a sin/cos ROM and a sequential shift-add multiplier, then applies scale and origin offset.

Parameters:
- ORIGIN_X, 512, screen x pixel of the sensor origin.
- ORIGIN_Y, 700, screen y pixel of the sensor origin (y grows downward).
- SCALE_SHIFT, 1, pixels per inch = 2^SCALE_SHIFT, applied after the multiply.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- location_done  in  1  upstream done level; a rising edge starts a conversion
- rover_location  in  12  {angle code[11:8], distance[7:0]}; sampled on the start edge
- busy  out  1  high while a conversion is in progress
- result_valid  out  1  one-cycle pulse when the outputs below are updated
- x_pixel  out  11  screen x coordinate
- y_pixel  out  10  screen y coordinate
- angle_error  out  1  last request had an angle code of 12..15
- no_target  out  1  last valid request had distance 0

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values:
  - x_pixel = ORIGIN_X, y_pixel = ORIGIN_Y.
  - busy, result_valid, angle_error, no_target = 0.
  - State = IDLE.
  - Edge-history register = 1, so a done level held through reset does not trigger.
- Reset mid-conversion aborts immediately and produces no result_valid.
- Start: in IDLE, location_done = 1 with history = 0 (cycle E) latches rover_location and moves to LOOKUP.
  - The history register updates every cycle in all states.
  - Edges seen while busy are dropped, never queued.
- LOOKUP (E+1), busy = 1:
  - If angle >= 12: set angle_error = 1, hold x/y/no_target, go to DONE. result_valid occurs at E+2.
  - Otherwise: clear angle_error, load 9-bit Q1.8 magnitudes COS[k] and SIN[k], clear both accumulators and the iteration counter, go to MULTIPLY.
- ROM magnitudes, k = 0..11:
  - COS: 256, 247, 222, 181, 128, 66, 0, 66, 128, 181, 222, 247.
  - SIN: 0, 66, 128, 181, 222, 247, 256, 247, 222, 181, 128, 66.
  - cos_neg = 1 for k >= 7.
- MULTIPLY (E+2..E+10, exactly 9 cycles):
  - Both products are computed in parallel over coefficient bits 0..8, one bit per cycle.
  - Each cycle: if coefficient bit i = 1, acc += distance << i.
  - Accumulators are 17 bits and never overflow (max 255*256).
- OFFSET (E+11):
  - px = acc_cos[16:8] << SCALE_SHIFT, py = acc_sin[16:8] << SCALE_SHIFT (truncating, no rounding).
  - x_pixel = cos_neg ? ORIGIN_X - px : ORIGIN_X + px.
  - y_pixel = ORIGIN_Y - py.
  - no_target = (distance == 0).
  - Go to DONE.
- DONE (E+12): result_valid = 1 for exactly one cycle, busy = 1. Next cycle: IDLE, busy = 0.
- Outputs hold their values between results.
- Next start: the earliest new edge is accepted at E+13.
- With default parameters all results stay on screen: x in 2..1022, y in 190..700. No clamping logic is required.

Test Plan:
- Angle 6, distance 100 (0x664) edge at E -> result_valid only at E+12; x_pixel = 512, y_pixel = 500, angle_error = 0, no_target = 0; busy high E+1..E+12.
- Angle 1, distance 200 (0x1C8) -> x_pixel = 896, y_pixel = 598.
- Angle 9, distance 255 (0x9FF) -> x_pixel = 152, y_pixel = 340 (negative-cos path).
- Angle 13 (0xD50) after a valid result -> result_valid at E+2, angle_error = 1, x/y unchanged; then angle 3, distance 0 -> angle_error = 0, no_target = 1, x = 512, y = 700.
- Second edge at E+5 while busy -> ignored, exactly one result_valid. location_done held high from reset release -> no conversion until it drops and rises again.
- Reset asserted at E+6 (during MULTIPLY) -> busy = 0 next cycle, no result_valid, x = 512, y = 700; a fresh edge afterwards converts normally with 12-cycle latency.
